// File: rtl/xor_32bit.sv
// xor_32bit: registered 32-bit bitwise XOR with zero, parity and popcount flags

// xor_cell: one-bit XOR built only from AND/OR/NOT gates
module xor_cell (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = (i_a & ~i_b) | (~i_a & i_b);
endmodule

module xor_32bit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] ones
);
    logic [WIDTH-1:0] w_res;
    logic [1:0]       w_l1 [16];
    logic [2:0]       w_l2 [8];
    logic [3:0]       w_l3 [4];
    logic [4:0]       w_l4 [2];
    logic [5:0]       w_cnt;
    logic             w_zero;
    logic             w_parity;

    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic             r_zero;
    logic             r_parity;
    logic [CNT_W-1:0] r_ones;

    genvar i;

    // One XOR cell per result bit
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            xor_cell u_cell (
                .i_a (a[i]),
                .i_b (b[i]),
                .o_y (w_res[i])
            );
        end
    endgenerate

    // Popcount as a balanced adder tree; each level widens by one bit so 32 is exact
    generate
        for (i = 0; i < 16; i++) begin : g_l1
            assign w_l1[i] = {1'b0, w_res[2*i]} + {1'b0, w_res[2*i+1]};
        end
        for (i = 0; i < 8; i++) begin : g_l2
            assign w_l2[i] = {1'b0, w_l1[2*i]} + {1'b0, w_l1[2*i+1]};
        end
        for (i = 0; i < 4; i++) begin : g_l3
            assign w_l3[i] = {1'b0, w_l2[2*i]} + {1'b0, w_l2[2*i+1]};
        end
        for (i = 0; i < 2; i++) begin : g_l4
            assign w_l4[i] = {1'b0, w_l3[2*i]} + {1'b0, w_l3[2*i+1]};
        end
    endgenerate

    assign w_cnt    = {1'b0, w_l4[0]} + {1'b0, w_l4[1]};
    assign w_zero   = ~|w_res;
    assign w_parity = ^w_res;

    // Result/flag register: reset forces a consistent zero result, otherwise load on valid and hold when idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_zero      <= 1'b1;
            r_parity    <= 1'b0;
            r_ones      <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out    <= w_res;
                r_zero   <= w_zero;
                r_parity <= w_parity;
                r_ones   <= w_cnt;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign zero      = r_zero;
    assign parity    = r_parity;
    assign ones      = r_ones;
endmodule

// File: tb/tb_xor_32bit.sv
// tb_xor_32bit: scoreboard bench for the registered XOR unit
module tb_xor_32bit;
    typedef struct packed {
        logic [31:0] o;
        logic        z;
        logic        p;
        logic [5:0]  n;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] out;
    logic        out_valid;
    logic        zero;
    logic        parity;
    logic [5:0]  ones;

    int   n_cmp = 0;
    int   n_err = 0;
    res_t q[$];
    res_t hold = '{o: 32'h0, z: 1'b1, p: 1'b0, n: 6'd0};

    xor_32bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out       (out),
        .out_valid (out_valid),
        .zero      (zero),
        .parity    (parity),
        .ones      (ones)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
        res_t r;
        r.o = 32'h0;
        r.n = 6'd0;
        r.p = 1'b0;
        for (int k = 0; k < 32; k++) begin
            r.o[k] = (x[k] != y[k]);
            if (x[k] != y[k]) begin
                r.n = r.n + 6'd1;
                r.p = ~r.p;
            end
        end
        r.z = (r.n == 6'd0);
        return r;
    endfunction

    task automatic step(input logic [31:0] va, input logic [31:0] vb, input logic v,
                        input logic r, input res_t e);
        logic exp_v;
        a = va;
        b = vb;
        in_valid = v;
        rst_n = r;
        @(posedge clk);
        if (!r) begin
            q.delete();
            hold = '{o: 32'h0, z: 1'b1, p: 1'b0, n: 6'd0};
            exp_v = 1'b0;
        end else begin
            if (v) q.push_back(e);
            exp_v = v;
        end
        #1;
        check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
        if (out_valid) begin
            if (q.size() == 0) check("spurious", 32'd1, 32'd0);
            else hold = q.pop_front();
        end
        check("out", out, hold.o);
        check("zero", {31'b0, zero}, {31'b0, hold.z});
        check("parity", {31'b0, parity}, {31'b0, hold.p});
        check("ones", {26'b0, ones}, {26'b0, hold.n});
        check("pending", q.size(), 32'd0);
    endtask

    initial begin
        step($urandom, $urandom, 1'b1, 1'b0, '0);
        step($urandom, $urandom, 1'b1, 1'b0, '0);
        step(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, '{o: 32'hFFFFFFFF, z: 1'b0, p: 1'b0, n: 6'd32});
        step(32'h12311111, 32'h00100000, 1'b1, 1'b1, '{o: 32'h12211111, z: 1'b0, p: 1'b0, n: 6'd8});
        step(32'h10000100, 32'h11000010, 1'b1, 1'b1, '{o: 32'h01000110, z: 1'b0, p: 1'b1, n: 6'd3});
        step(32'h11111000, 32'h00001111, 1'b1, 1'b1, '{o: 32'h11110111, z: 1'b0, p: 1'b1, n: 6'd7});
        step(32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b1, '{o: 32'h0, z: 1'b1, p: 1'b0, n: 6'd0});
        step(32'h00000001, 32'h00000000, 1'b1, 1'b1, '{o: 32'h1, z: 1'b0, p: 1'b1, n: 6'd1});
        step(32'h12345678, 32'hEDCBA987, 1'b1, 1'b1, '{o: 32'hFFFFFFFF, z: 1'b0, p: 1'b0, n: 6'd32});
        step(32'hAAAA0000, 32'hAAAAFFFF, 1'b1, 1'b1, '{o: 32'h0000FFFF, z: 1'b0, p: 1'b0, n: 6'd16});
        for (int k = 0; k < 3; k++) step($urandom, $urandom, 1'b0, 1'b1, '0);
        step(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b0, '0);
        step($urandom, $urandom, 1'b0, 1'b1, '0);
        for (int k = 0; k < 10000; k++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (k % 97 == 0) ? ra : (k % 89 == 0) ? ~ra : $urandom;
            step(ra, rb, 1'b1, 1'b1, model(ra, rb));
        end
        step(32'h0, 32'h0, 1'b0, 1'b1, '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
